// File: rtl/arm_microsequencer.sv
// Control-unit next-state engine: walks the microstore under ns_ctl commands,
// dispatches to encoder entry states, and tracks MOC waits, halt and retired count.
module arm_microsequencer #(
  parameter logic [6:0] FETCH_STATE = 7'd1,
  parameter logic [6:0] ABORT_STATE = 7'd127,
  parameter int         MOC_TIMEOUT = 16,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hold,
  input  logic [2:0]       ns_ctl,
  input  logic [6:0]       ns_target,
  input  logic [6:0]       enc_state,
  input  logic             cond_pass,
  input  logic             moc,
  output logic [6:0]       state,
  output logic             dispatched,
  output logic             halted,
  output logic             mem_fault,
  output logic [CNT_W-1:0] instr_count
);

  localparam int TW = $clog2(MOC_TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(MOC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    CMD_INC       = 3'b000,
    CMD_JUMP      = 3'b001,
    CMD_DISPATCH  = 3'b010,
    CMD_WAIT_MOC  = 3'b011,
    CMD_COND_JUMP = 3'b100,
    CMD_RET_FETCH = 3'b101,
    CMD_HALT      = 3'b110,
    CMD_RESERVED  = 3'b111
  } nsCmd_e;

  logic [6:0]       stateReg, stateNext;
  logic             dispatchedReg, dispatchedNext;
  logic             haltedReg, haltedNext;
  logic             memFaultReg, memFaultNext;
  logic [CNT_W-1:0] instrCountReg, instrCountNext;
  logic [TW-1:0]    timerReg, timerNext;
  nsCmd_e           cmd;
  logic [6:0]       stateInc;
  logic             timeoutHit;

  // Once halted, the engine ignores the microstore until reset.
  always_comb begin
    cmd = haltedReg ? CMD_HALT : nsCmd_e'(ns_ctl);
  end

  assign stateInc   = stateReg + 7'd1;
  assign timeoutHit = (MOC_TIMEOUT != 0) && (timerReg == TIMER_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateReg      <= '0;
      dispatchedReg <= 1'b0;
      haltedReg     <= 1'b0;
      memFaultReg   <= 1'b0;
      instrCountReg <= '0;
      timerReg      <= '0;
    end else begin
      stateReg      <= stateNext;
      dispatchedReg <= dispatchedNext;
      haltedReg     <= haltedNext;
      memFaultReg   <= memFaultNext;
      instrCountReg <= instrCountNext;
      timerReg      <= timerNext;
    end
  end

  always_comb begin
    stateNext      = stateReg;
    dispatchedNext = 1'b0;
    haltedNext     = haltedReg;
    memFaultNext   = memFaultReg;
    instrCountNext = instrCountReg;
    timerNext      = '0;
    if (hold) begin
      timerNext = timerReg;
    end else begin
      case (cmd)
        CMD_INC:       stateNext = stateInc;
        CMD_JUMP:      stateNext = ns_target;
        CMD_DISPATCH: begin
          if (cond_pass && (enc_state != 7'd0)) begin
            stateNext      = enc_state;
            dispatchedNext = 1'b1;
            instrCountNext = instrCountReg + CNT_W'(1);
          end else begin
            stateNext = FETCH_STATE;
          end
        end
        CMD_WAIT_MOC: begin
          // A late moc in the final wait cycle still counts as success.
          if (moc) begin
            stateNext = stateInc;
          end else if (timeoutHit) begin
            stateNext    = ABORT_STATE;
            memFaultNext = 1'b1;
          end else begin
            timerNext = timerReg + TW'(1);
          end
        end
        CMD_COND_JUMP: stateNext = cond_pass ? ns_target : stateInc;
        CMD_RET_FETCH: stateNext = FETCH_STATE;
        CMD_HALT:      haltedNext = 1'b1;
        CMD_RESERVED:  stateNext = FETCH_STATE;
      endcase
    end
  end

  assign state       = stateReg;
  assign dispatched  = dispatchedReg;
  assign halted      = haltedReg;
  assign mem_fault   = memFaultReg;
  assign instr_count = instrCountReg;

endmodule

// File: tb/tb_arm_microsequencer.sv
// Directed bench for arm_microsequencer: a command-level reference model checked
// every cycle, plus hand-computed expectations at key points of the sequence.
module tb_arm_microsequencer;

  localparam int MOC_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hold;
  logic [2:0]  ns_ctl;
  logic [6:0]  ns_target;
  logic [6:0]  enc_state;
  logic        cond_pass;
  logic        moc;
  logic [6:0]  state;
  logic        dispatched;
  logic        halted;
  logic        mem_fault;
  logic [15:0] instr_count;

  int vectors = 0;
  int miscompares = 0;
  bit checkOn = 1'b0;

  // reference model
  int mState = 0;
  int mCount = 0;
  int mWait = 0;
  bit mDisp = 1'b0;
  bit mHalted = 1'b0;
  bit mFault = 1'b0;
  int mCmd;

  arm_microsequencer #(
    .FETCH_STATE(7'd1),
    .ABORT_STATE(7'd127),
    .MOC_TIMEOUT(MOC_TIMEOUT),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .hold(hold),
    .ns_ctl(ns_ctl),
    .ns_target(ns_target),
    .enc_state(enc_state),
    .cond_pass(cond_pass),
    .moc(moc),
    .state(state),
    .dispatched(dispatched),
    .halted(halted),
    .mem_fault(mem_fault),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign mCmd = mHalted ? 6 : int'(ns_ctl);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mState  <= 0;
      mCount  <= 0;
      mWait   <= 0;
      mDisp   <= 1'b0;
      mHalted <= 1'b0;
      mFault  <= 1'b0;
    end else if (hold) begin
      mDisp <= 1'b0;
    end else begin
      mDisp <= 1'b0;
      mWait <= 0;
      case (mCmd)
        0: mState <= (mState + 1) % 128;
        1: mState <= int'(ns_target);
        2: begin
          if (cond_pass && enc_state != 0) begin
            mState <= int'(enc_state);
            mDisp  <= 1'b1;
            mCount <= (mCount + 1) % 65536;
          end else begin
            mState <= 1;
          end
        end
        3: begin
          if (moc) mState <= (mState + 1) % 128;
          else if (MOC_TIMEOUT != 0 && mWait == MOC_TIMEOUT - 1) begin
            mState <= 127;
            mFault <= 1'b1;
          end else mWait <= mWait + 1;
        end
        4: mState <= cond_pass ? int'(ns_target) : (mState + 1) % 128;
        6: mHalted <= 1'b1;
        default: mState <= 1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (checkOn) begin
      vectors++;
      if (state !== 7'(mState) || dispatched !== mDisp || halted !== mHalted ||
          mem_fault !== mFault || instr_count !== 16'(mCount)) begin
        miscompares++;
        $display("FAIL model t=%0t: got state=%0d disp=%0b halt=%0b fault=%0b cnt=%0d, expected state=%0d disp=%0b halt=%0b fault=%0b cnt=%0d",
                 $time, state, dispatched, halted, mem_fault, instr_count,
                 mState, mDisp, mHalted, mFault, mCount);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick(input logic [2:0] c, input logic [6:0] t, input logic [6:0] e,
                      input logic cp, input logic m, input logic h);
    ns_ctl = c; ns_target = t; enc_state = e; cond_pass = cp; moc = m; hold = h;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_state", int'(state), 0);
    check("async_reset_halted", int'(halted), 0);
    check("async_reset_fault", int'(mem_fault), 0);
    check("async_reset_count", int'(instr_count), 0);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b1; hold = 1'b1; ns_ctl = 3'd0; ns_target = 7'd0;
    enc_state = 7'd0; cond_pass = 1'b0; moc = 1'b0;
    #3 reset_n = 1'b0;
    #9 reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOn = 1'b1;
    check("reset_state", int'(state), 0);
    check("reset_disp", int'(dispatched), 0);
    check("reset_count", int'(instr_count), 0);

    // INC sequence, then asynchronous reset between edges
    for (int i = 1; i <= 3; i++) begin
      tick(3'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
      check("inc_state", int'(state), i);
    end
    pulseReset();

    // dispatch cases
    tick(3'd1, 7'd5, 7'd0, 1'b0, 1'b0, 1'b0);
    tick(3'd2, 7'd0, 7'd43, 1'b1, 1'b0, 1'b0);
    check("disp_state", int'(state), 43);
    check("disp_flag", int'(dispatched), 1);
    check("disp_count", int'(instr_count), 1);
    tick(3'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    check("disp_flag_drop", int'(dispatched), 0);
    tick(3'd2, 7'd0, 7'd43, 1'b0, 1'b0, 1'b0);
    check("condfail_state", int'(state), 1);
    check("condfail_count", int'(instr_count), 1);
    check("condfail_disp", int'(dispatched), 0);
    tick(3'd2, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
    check("nop_state", int'(state), 1);
    check("nop_count", int'(instr_count), 1);
    tick(3'd2, 7'd0, 7'd20, 1'b1, 1'b0, 1'b0);
    tick(3'd1, 7'd99, 7'd0, 1'b0, 1'b0, 1'b1);
    check("hold_state", int'(state), 20);
    check("hold_disp", int'(dispatched), 0);
    check("hold_count", int'(instr_count), 2);

    // WAIT_MOC with moc after 5 cycles
    tick(3'd1, 7'd10, 7'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(3'd3, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    check("wait_state", int'(state), 10);
    tick(3'd3, 7'd0, 7'd0, 1'b0, 1'b1, 1'b0);
    check("moc_state", int'(state), 11);
    check("moc_fault", int'(mem_fault), 0);

    // moc arrives in the final timeout cycle
    tick(3'd1, 7'd10, 7'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) tick(3'd3, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    check("edge_wait_state", int'(state), 10);
    tick(3'd3, 7'd0, 7'd0, 1'b0, 1'b1, 1'b0);
    check("edge_state", int'(state), 11);
    check("edge_fault", int'(mem_fault), 0);

    // timeout with a 4-cycle hold in the middle
    tick(3'd1, 7'd10, 7'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(3'd3, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(3'd3, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) tick(3'd3, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    check("prefault_state", int'(state), 10);
    check("prefault_fault", int'(mem_fault), 0);
    tick(3'd3, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    check("abort_state", int'(state), 127);
    check("abort_fault", int'(mem_fault), 1);
    tick(3'd5, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    check("retfetch_state", int'(state), 1);
    check("sticky_fault", int'(mem_fault), 1);

    // conditional jump, wrap, reserved command
    tick(3'd1, 7'd30, 7'd0, 1'b0, 1'b0, 1'b0);
    tick(3'd4, 7'd60, 7'd0, 1'b1, 1'b0, 1'b0);
    check("cjump_taken", int'(state), 60);
    tick(3'd4, 7'd90, 7'd0, 1'b0, 1'b0, 1'b0);
    check("cjump_not_taken", int'(state), 61);
    tick(3'd1, 7'd127, 7'd0, 1'b0, 1'b0, 1'b0);
    tick(3'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    check("inc_wrap", int'(state), 0);
    tick(3'd1, 7'd50, 7'd0, 1'b0, 1'b0, 1'b0);
    tick(3'd7, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    check("reserved_state", int'(state), 1);

    // HALT for 50 cycles, then reset exits it
    tick(3'd1, 7'd70, 7'd0, 1'b0, 1'b0, 1'b0);
    tick(3'd6, 7'd5, 7'd0, 1'b1, 1'b1, 1'b0);
    check("halt_flag", int'(halted), 1);
    check("halt_state", int'(state), 70);
    for (int i = 0; i < 50; i++) tick(3'd6, 7'(i), 7'd9, 1'b1, 1'b1, 1'b0);
    check("halt_state_50", int'(state), 70);
    check("halt_flag_50", int'(halted), 1);
    pulseReset();
    tick(3'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    check("post_reset_inc", int'(state), 1);

    checkOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
